pipeline_controller: RTL and testbench

PIPELINE_CONTROLLER -- requirements
Module: pipeline_controller

---
 rtl/cpu_ctrl_pkg.sv | 22 ++
 rtl/hazard_detect.sv | 29 ++
 rtl/pipeline_controller.sv | 128 ++++++++++++
 tb/tb_pipeline_controller.sv | 201 ++++++++++++++++++++
 4 files changed

// File: rtl/cpu_ctrl_pkg.sv
`default_nettype none
// ============================================================================
// Module   : cpu_ctrl_pkg
// Purpose  : Shared controller state encoding, defaults and helpers.
// Revision : 1.0
// ============================================================================
package cpu_ctrl_pkg;

  typedef enum logic [1:0] {
    ST_HALT  = 2'd0,
    ST_RUN   = 2'd1,
    ST_DRAIN = 2'd2
  } ctrl_state_e;

  localparam int DEFAULT_DRAIN_CYCLES = 4;

  function automatic logic [15:0] sat_inc16(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

endpackage
`default_nettype wire

// File: rtl/hazard_detect.sv
`default_nettype none
// ============================================================================
// Module   : hazard_detect
// Purpose  : Combinational load-use hazard detection between ID/EX and IF/ID.
// Revision : 1.0
// ============================================================================
module hazard_detect #(
  parameter int REG_ADDR_W = 3
) (
  input  logic                  idex_mem_read_i,
  input  logic [REG_ADDR_W-1:0] idex_rd_i,
  input  logic [REG_ADDR_W-1:0] ifid_rs_i,
  input  logic [REG_ADDR_W-1:0] ifid_rt_i,
  input  logic                  ifid_uses_rt_i,
  output logic                  load_use_o
);

  logic w_rd_nonzero;
  logic w_rs_match;
  logic w_rt_match;

  // Register 0 is hard-wired, so a load targeting it never creates a dependency.
  assign w_rd_nonzero = (idex_rd_i != '0);
  assign w_rs_match   = (idex_rd_i == ifid_rs_i);
  assign w_rt_match   = ifid_uses_rt_i && (idex_rd_i == ifid_rt_i);
  assign load_use_o   = idex_mem_read_i && w_rd_nonzero && (w_rs_match || w_rt_match);

endmodule
`default_nettype wire

// File: rtl/pipeline_controller.sv
`default_nettype none
// ============================================================================
// Module   : pipeline_controller
// Purpose  : Run/drain/halt FSM, per-stage enables, hazard controls, counters.
// Revision : 1.0
// ============================================================================
module pipeline_controller
  import cpu_ctrl_pkg::*;
#(
  parameter int REG_ADDR_W   = 3,
  parameter int DRAIN_CYCLES = DEFAULT_DRAIN_CYCLES
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  exec,
  input  logic                  halt_cmd,
  input  logic                  idex_mem_read,
  input  logic [REG_ADDR_W-1:0] idex_rd,
  input  logic [REG_ADDR_W-1:0] ifid_rs,
  input  logic [REG_ADDR_W-1:0] ifid_rt,
  input  logic                  ifid_uses_rt,
  input  logic                  branch_taken,
  output logic                  en_pc,
  output logic                  en_ifid,
  output logic                  en_idex,
  output logic                  en_exmem,
  output logic                  en_memwb,
  output logic                  stall_pc,
  output logic                  stall_ifid,
  output logic                  flush_ifid,
  output logic                  flush_idex,
  output logic                  is_halt_now,
  output logic [15:0]           stall_count,
  output logic [15:0]           flush_count
);

  localparam int                C_DCNT_W     = (DRAIN_CYCLES > 1) ? $clog2(DRAIN_CYCLES) : 1;
  localparam logic [C_DCNT_W-1:0] C_DRAIN_LOAD = C_DCNT_W'(DRAIN_CYCLES - 1);

  ctrl_state_e          state_q, state_d;
  logic [C_DCNT_W-1:0]  drain_q, drain_d;
  logic [15:0]          stall_cnt_q, stall_cnt_d;
  logic [15:0]          flush_cnt_q, flush_cnt_d;
  logic                 w_load_use;

  hazard_detect #(
    .REG_ADDR_W(REG_ADDR_W)
  ) u_hazard_detect (
    .idex_mem_read_i(idex_mem_read),
    .idex_rd_i      (idex_rd),
    .ifid_rs_i      (ifid_rs),
    .ifid_rt_i      (ifid_rt),
    .ifid_uses_rt_i (ifid_uses_rt),
    .load_use_o     (w_load_use)
  );

  always_comb begin
    state_d     = state_q;
    drain_d     = drain_q;
    stall_cnt_d = stall_cnt_q;
    flush_cnt_d = flush_cnt_q;
    en_pc       = 1'b0;
    en_ifid     = 1'b0;
    en_idex     = 1'b0;
    en_exmem    = 1'b0;
    en_memwb    = 1'b0;
    stall_pc    = 1'b0;
    stall_ifid  = 1'b0;
    flush_ifid  = 1'b0;
    flush_idex  = 1'b0;
    is_halt_now = 1'b0;

    case (state_q)
      ST_HALT: begin
        is_halt_now = 1'b1;
        if (exec) state_d = ST_RUN;
      end
      ST_RUN: begin
        {en_pc, en_ifid, en_idex, en_exmem, en_memwb} = 5'b11111;
        // A taken branch discards the dependent instruction, so it overrides the stall.
        if (branch_taken) begin
          flush_ifid  = 1'b1;
          flush_idex  = 1'b1;
          flush_cnt_d = sat_inc16(flush_cnt_q);
        end else if (w_load_use) begin
          stall_pc    = 1'b1;
          stall_ifid  = 1'b1;
          flush_idex  = 1'b1;
          stall_cnt_d = sat_inc16(stall_cnt_q);
        end
        if (exec || halt_cmd) begin
          state_d = ST_DRAIN;
          drain_d = C_DRAIN_LOAD;
        end
      end
      ST_DRAIN: begin
        {en_ifid, en_idex, en_exmem, en_memwb} = 4'b1111;
        flush_ifid = 1'b1;
        if (drain_q == '0) state_d = ST_HALT;
        else               drain_d = drain_q - C_DCNT_W'(1);
      end
      default: begin
        is_halt_now = 1'b1;
        state_d     = ST_HALT;
        drain_d     = '0;
      end
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q     <= ST_HALT;
      drain_q     <= '0;
      stall_cnt_q <= 16'd0;
      flush_cnt_q <= 16'd0;
    end else begin
      state_q     <= state_d;
      drain_q     <= drain_d;
      stall_cnt_q <= stall_cnt_d;
      flush_cnt_q <= flush_cnt_d;
    end
  end

  assign stall_count = stall_cnt_q;
  assign flush_count = flush_cnt_q;

endmodule
`default_nettype wire

// File: tb/tb_pipeline_controller.sv
`default_nettype none
// ============================================================================
// Module   : tb_pipeline_controller
// Purpose  : Randomized, scoreboard-checked bench for pipeline_controller.
// Revision : 1.0
// ============================================================================
module tb_pipeline_controller;

  localparam int RW = 3;
  localparam int DC = 4;

  logic          clock = 1'b0;
  logic          reset, exec, halt_cmd, idex_mem_read, ifid_uses_rt, branch_taken;
  logic [RW-1:0] idex_rd, ifid_rs, ifid_rt;
  logic          en_pc, en_ifid, en_idex, en_exmem, en_memwb;
  logic          stall_pc, stall_ifid, flush_ifid, flush_idex, is_halt_now;
  logic [15:0]   stall_count, flush_count;

  pipeline_controller #(.REG_ADDR_W(RW), .DRAIN_CYCLES(DC)) dut (
    .clock(clock), .reset(reset), .exec(exec), .halt_cmd(halt_cmd),
    .idex_mem_read(idex_mem_read), .idex_rd(idex_rd),
    .ifid_rs(ifid_rs), .ifid_rt(ifid_rt), .ifid_uses_rt(ifid_uses_rt),
    .branch_taken(branch_taken),
    .en_pc(en_pc), .en_ifid(en_ifid), .en_idex(en_idex), .en_exmem(en_exmem), .en_memwb(en_memwb),
    .stall_pc(stall_pc), .stall_ifid(stall_ifid), .flush_ifid(flush_ifid), .flush_idex(flush_idex),
    .is_halt_now(is_halt_now), .stall_count(stall_count), .flush_count(flush_count)
  );

  always #5 clock = ~clock;

  typedef struct {
    int unsigned cyc;
    string       tag;
    logic [4:0]  en;   // {pc, ifid, idex, exmem, memwb}
    logic [3:0]  hz;   // {stall_pc, stall_ifid, flush_ifid, flush_idex}
    logic        halt;
    logic [15:0] sc;
    logic [15:0] fc;
  } exp_t;

  exp_t        sb[$];
  int unsigned cyc = 0;
  int          n_checks = 0;
  int          n_errors = 0;

  // Reference model: mode name, remaining drain cycles, plain integer counters.
  typedef enum {M_HALT, M_RUN, M_DRAIN} mode_e;
  mode_e m_mode = M_HALT;
  int    m_left = 0;
  int    m_sc   = 0;
  int    m_fc   = 0;

  always @(posedge clock) cyc <= cyc + 1;

  task automatic cmp(input string tag, input string fld, input logic [15:0] got, input logic [15:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s.%s cyc=%0d got=%h exp=%h", tag, fld, cyc, got, exp);
    end
  endtask

  exp_t me;
  always @(negedge clock) begin
    if (sb.size() > 0 && sb[0].cyc == cyc) begin
      me = sb.pop_front();
      cmp(me.tag, "en",   16'({en_pc, en_ifid, en_idex, en_exmem, en_memwb}), 16'(me.en));
      cmp(me.tag, "hz",   16'({stall_pc, stall_ifid, flush_ifid, flush_idex}), 16'(me.hz));
      cmp(me.tag, "halt", 16'(is_halt_now), 16'(me.halt));
      cmp(me.tag, "scnt", stall_count, me.sc);
      cmp(me.tag, "fcnt", flush_count, me.fc);
    end
  end

  function automatic bit hazard_now();
    return idex_mem_read && (idex_rd != 0) &&
           ((idex_rd == ifid_rs) || (ifid_uses_rt && (idex_rd == ifid_rt)));
  endfunction

  task automatic drive(input logic ex, input logic hc, input logic mr, input int rd,
                       input int rs, input int rt, input logic ut, input logic br);
    exec = ex; halt_cmd = hc; idex_mem_read = mr;
    idex_rd = RW'(rd); ifid_rs = RW'(rs); ifid_rt = RW'(rt);
    ifid_uses_rt = ut; branch_taken = br;
  endtask

  // Push the expected response for the current cycle, then advance one edge.
  task automatic step(input string tag, input bit chk);
    exp_t e;
    bit   hz;
    hz    = hazard_now();
    e.cyc = cyc;
    e.tag = tag;
    e.sc  = 16'(m_sc);
    e.fc  = 16'(m_fc);
    case (m_mode)
      M_HALT:  begin e.en = 5'b00000; e.hz = 4'b0000; e.halt = 1'b1; end
      M_RUN:   begin
        e.en = 5'b11111; e.halt = 1'b0;
        e.hz = branch_taken ? 4'b0011 : (hz ? 4'b1101 : 4'b0000);
      end
      default: begin e.en = 5'b01111; e.hz = 4'b0010; e.halt = 1'b0; end
    endcase
    if (chk) sb.push_back(e);
    @(posedge clock);
    if (reset) begin
      m_mode = M_HALT; m_left = 0; m_sc = 0; m_fc = 0;
    end else begin
      case (m_mode)
        M_HALT: if (exec) m_mode = M_RUN;
        M_RUN: begin
          if (branch_taken)  begin if (m_fc < 65535) m_fc++; end
          else if (hz)       begin if (m_sc < 65535) m_sc++; end
          if (exec || halt_cmd) begin m_mode = M_DRAIN; m_left = DC; end
        end
        default: begin
          m_left--;
          if (m_left == 0) m_mode = M_HALT;
        end
      endcase
    end
    #1;
  endtask

  initial begin
    reset = 1'b1;
    drive(0, 0, 0, 0, 0, 0, 0, 0);
    @(posedge clock); #1;
    step("rst0", 0);
    step("rst1", 1);
    reset = 1'b0;
    step("halt_idle", 1);
    drive(0, 1, 1, 3, 3, 0, 0, 1);
    step("halt_ignores_cmd", 1);
    drive(1, 0, 0, 0, 0, 0, 0, 0);
    step("exec_pulse", 1);
    drive(0, 0, 0, 0, 0, 0, 0, 0);
    step("run_entered", 1);

    drive(0, 0, 1, 3, 3, 0, 0, 0);
    step("loaduse_rs", 1);
    drive(0, 0, 0, 0, 0, 0, 0, 0);
    step("stall_cnt1", 1);
    drive(0, 0, 1, 0, 0, 0, 0, 0);
    step("rd_zero", 1);
    drive(0, 0, 1, 3, 1, 3, 0, 0);
    step("rt_unused", 1);
    drive(0, 0, 1, 3, 1, 3, 1, 0);
    step("rt_used", 1);
    drive(0, 0, 1, 3, 3, 0, 0, 1);
    step("branch_wins", 1);
    drive(0, 0, 0, 0, 0, 0, 0, 0);
    step("after_branch", 1);

    drive(0, 1, 1, 2, 2, 0, 0, 1);
    step("halt_and_branch", 1);
    drive(1, 0, 1, 2, 2, 0, 0, 1);
    step("drain_exec_ign", 1);
    drive(0, 0, 0, 0, 0, 0, 0, 0);
    for (int i = 0; i < DC + 1; i++) step("drain_tail", 1);
    step("halted_again", 1);

    for (int i = 0; i < 400; i++) begin
      reset = ($urandom_range(0, 63) == 0);
      drive($urandom_range(0, 15) == 0, $urandom_range(0, 15) == 0, $urandom_range(0, 1),
            $urandom_range(0, 3), $urandom_range(0, 3), $urandom_range(0, 3),
            $urandom_range(0, 1), $urandom_range(0, 3) == 0);
      step("random", 1);
    end
    reset = 1'b0;
    drive(0, 0, 0, 0, 0, 0, 0, 0);
    for (int i = 0; i < DC + 2; i++) step("settle", 1);

    drive(1, 0, 0, 0, 0, 0, 0, 0);
    step("sat_start", 1);
    drive(0, 0, 1, 5, 5, 0, 0, 0);
    for (int i = 0; i < 65540; i++) step("sat_burn", (i % 8192 == 0) || (i > 65530));
    drive(0, 0, 0, 0, 0, 0, 0, 0);
    step("sat_hold", 1);
    drive(0, 1, 1, 5, 5, 0, 0, 0);
    step("sat_halt", 1);
    drive(0, 0, 0, 0, 0, 0, 0, 0);
    step("mid_drain", 1);
    reset = 1'b1;
    step("reset_in_drain", 1);
    reset = 1'b0;
    drive(0, 0, 1, 5, 5, 0, 0, 1);
    step("post_reset", 1);
    step("post_reset2", 1);

    @(negedge clock); #1;
    if (sb.size() != 0) begin
      n_errors++;
      $display("FAIL scoreboard_drain left=%0d required=0", sb.size());
    end
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
`default_nettype wire
